// File: rtl/router_pkg.sv
// Shared types for the router switch allocator: port indices, widths and the
// per-output FSM state encoding.
package router_pkg;

  localparam int NUM_OUT = 5;
  localparam int PORT_W  = 3;

  typedef enum logic [PORT_W-1:0] {
    PORT_LOCAL = 3'd0,
    PORT_EAST  = 3'd1,
    PORT_WEST  = 3'd2,
    PORT_NORTH = 3'd3,
    PORT_SOUTH = 3'd4
  } port_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/router_route_calc.sv
// Combinational XY route: X offset is resolved first, then Y, else LOCAL.
// Offsets are two's complement; the sign bit alone decides "negative".
module router_route_calc
  import router_pkg::*;
#(
  parameter int COORD_W = 30
) (
  input  logic [COORD_W-1:0] i_dest_x,
  input  logic [COORD_W-1:0] i_dest_y,
  output logic [PORT_W-1:0]  o_port
);

  logic w_x_neg, w_x_pos, w_y_neg, w_y_pos;

  assign w_x_neg = i_dest_x[COORD_W-1];
  assign w_x_pos = !i_dest_x[COORD_W-1] && (|i_dest_x);
  assign w_y_neg = i_dest_y[COORD_W-1];
  assign w_y_pos = !i_dest_y[COORD_W-1] && (|i_dest_y);

  always_comb begin
    o_port = PORT_LOCAL;
    if (w_x_pos)      o_port = PORT_EAST;
    else if (w_x_neg) o_port = PORT_WEST;
    else if (w_y_pos) o_port = PORT_NORTH;
    else if (w_y_neg) o_port = PORT_SOUTH;
  end

endmodule

// File: rtl/router_switch_alloc.sv
// Wormhole switch allocator: per-output round-robin grant, locked until tail.
// Optional per-output saturating flit counters: ROUTER_SWITCH_ALLOC_STATS_EN.
module router_switch_alloc
  import router_pkg::*;
#(
  parameter int N_IN    = 5,
  parameter int COORD_W = 30
`ifdef ROUTER_SWITCH_ALLOC_STATS_EN
  ,
  parameter int STAT_W  = 16
`endif
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_IN-1:0]           in_valid,
  input  logic [N_IN-1:0]           in_head,
  input  logic [N_IN-1:0]           in_tail,
  input  logic [N_IN*COORD_W-1:0]   in_dest_x,
  input  logic [N_IN*COORD_W-1:0]   in_dest_y,
  output logic [N_IN-1:0]           in_ready,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*PORT_W-1:0] out_sel,
  output logic [NUM_OUT-1:0]        out_busy
`ifdef ROUTER_SWITCH_ALLOC_STATS_EN
  ,
  input  logic                      clear_stats,
  output logic [NUM_OUT*STAT_W-1:0] out_flit_cnt
`endif
);

  // Handshake: a flit moves on a clock edge exactly when valid && ready are both
  // high; a locked output forwards in_valid downstream and out_ready upstream.

  logic [PORT_W-1:0]  w_route [N_IN];
  state_e             r_state [NUM_OUT];
  state_e             w_state_nxt [NUM_OUT];
  logic [PORT_W-1:0]  r_owner [NUM_OUT];
  logic [PORT_W-1:0]  w_owner_nxt [NUM_OUT];
  logic [PORT_W-1:0]  r_rr [NUM_OUT];
  logic [PORT_W-1:0]  w_rr_nxt [NUM_OUT];
  logic [N_IN-1:0]    r_in_lock;
  logic [N_IN-1:0]    w_in_lock_nxt;
  logic [N_IN-1:0]    w_req_ok;
  logic [NUM_OUT-1:0] w_xfer;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_route
    router_route_calc #(.COORD_W(COORD_W)) u_route (
      .i_dest_x (in_dest_x[gi*COORD_W +: COORD_W]),
      .i_dest_y (in_dest_y[gi*COORD_W +: COORD_W]),
      .o_port   (w_route[gi])
    );
  end

  assign w_req_ok = in_valid & in_head & ~r_in_lock;

  always_comb begin
    int   idx;
    logic found;
    idx           = 0;
    found         = 1'b0;
    in_ready      = '0;
    out_valid     = '0;
    out_sel       = '0;
    out_busy      = '0;
    w_xfer        = '0;
    w_in_lock_nxt = r_in_lock;
    for (int o = 0; o < NUM_OUT; o++) begin
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_rr_nxt[o]    = r_rr[o];
      if (r_state[o] == ST_LOCKED) begin
        out_busy[o]                   = 1'b1;
        out_sel[o*PORT_W +: PORT_W]   = r_owner[o];
        if (!reset) begin
          out_valid[o]         = in_valid[r_owner[o]];
          in_ready[r_owner[o]] = out_ready[o];
        end
        w_xfer[o] = !reset && in_valid[r_owner[o]] && out_ready[o];
        if (w_xfer[o] && in_tail[r_owner[o]]) begin
          w_state_nxt[o]               = ST_IDLE;
          w_rr_nxt[o]                  = (r_owner[o] == PORT_W'(N_IN-1)) ? '0 : r_owner[o] + 1'b1;
          w_in_lock_nxt[r_owner[o]]    = 1'b0;
        end
      end else begin
        // Grant only from IDLE, so a release and a new grant never share a cycle.
        found = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
          idx = (int'(r_rr[o]) + k) % N_IN;
          if (!found && w_req_ok[idx] && (w_route[idx] == PORT_W'(o))) begin
            found              = 1'b1;
            w_state_nxt[o]     = ST_LOCKED;
            w_owner_nxt[o]     = PORT_W'(idx);
            w_in_lock_nxt[idx] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_lock <= '0;
      for (int o = 0; o < NUM_OUT; o++) begin
        r_state[o] <= ST_IDLE;
        r_owner[o] <= '0;
        r_rr[o]    <= '0;
      end
    end else begin
      r_in_lock <= w_in_lock_nxt;
      for (int o = 0; o < NUM_OUT; o++) begin
        r_state[o] <= w_state_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_rr[o]    <= w_rr_nxt[o];
      end
    end
  end

`ifdef ROUTER_SWITCH_ALLOC_STATS_EN
  logic [STAT_W-1:0] r_cnt [NUM_OUT];

  always_ff @(posedge clock) begin
    for (int o = 0; o < NUM_OUT; o++) begin
      if (reset || clear_stats)               r_cnt[o] <= '0;
      else if (w_xfer[o] && (r_cnt[o] != '1)) r_cnt[o] <= r_cnt[o] + 1'b1;
    end
  end

  for (genvar go = 0; go < NUM_OUT; go++) begin : g_cnt
    assign out_flit_cnt[go*STAT_W +: STAT_W] = r_cnt[go];
  end
`endif

endmodule

// File: doc/router_switch_alloc.md
Name: router_switch_alloc

Overview:
- Sequential switch allocator for a 2D-mesh router node.
- N_IN input ports present flits. Each head flit carries signed 30-bit dest_x/dest_y offsets, which are turned into an XY output-port choice.
- Each of the 5 output ports is shared round-robin and locked per packet (wormhole) until the tail flit transfers.
- Sits between the input buffers and the crossbar; drives the crossbar select lines and all valid/ready handshakes.

Parameters:
- N_IN, 5, number of input ports (2..8)
- COORD_W, 30, width of the dest_x/dest_y signed offsets
- STAT_W, 16, width of the per-output flit counter (optional feature only)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  N_IN  flit valid per input
- in_head  in  N_IN  flit is a packet head; dest fields are meaningful only when this is 1
- in_tail  in  N_IN  flit is a packet tail; head and tail both 1 means a single-flit packet
- in_dest_x  in  N_IN*COORD_W  signed X offset, two's complement
- in_dest_y  in  N_IN*COORD_W  signed Y offset, two's complement
- in_ready  out  N_IN  flit accepted this cycle
- out_valid  out  5  flit presented on output o
- out_ready  in  5  downstream accepts on output o
- out_sel  out  5*3  crossbar input index per output; value is don't-care when out_valid[o]=0
- out_busy  out  5  output o is locked to a packet

Behaviour:
- Port indices: 0 LOCAL, 1 EAST, 2 WEST, 3 NORTH, 4 SOUTH.
- Route rule (XY):
  - dx>0 -> EAST; dx<0 -> WEST
  - else dy>0 -> NORTH; dy<0 -> SOUTH
  - else LOCAL
  - Full-width signed compare. The most-negative value routes WEST or SOUTH; no overflow handling.
- Per-output FSM, two states:
  - IDLE -> LOCKED(owner) when at least one input has in_valid & in_head & route==o and that input is not already locked.
  - The winner is chosen round-robin, starting the search at rr_ptr[o].
  - Grant is registered: the lock takes effect on the cycle after the request. No flit transfers in the request cycle.
- While LOCKED(owner):
  - out_valid[o] = in_valid[owner]
  - in_ready[owner] = out_ready[o]
  - out_sel[o] = owner
  - All three are combinational in this state.
  - Transfer condition: in_valid & in_ready.
  - A transfer with in_tail=1 -> IDLE next cycle, and rr_ptr[o] = (owner+1) mod N_IN.
- Per-input lock register: an input is locked to at most one output. Body flits ignore their dest fields.
- Simultaneous events:
  - Two inputs request the same output: the first at or after rr_ptr wins; the loser keeps in_ready=0.
  - Different outputs grant independently in the same cycle.
  - Tail release and a new grant are never in the same cycle; the output is IDLE for at least one cycle between packets.
- Inputs with no lock: in_ready=0.
- A non-head flit arriving at an unlocked input is held (in_ready=0) and never granted.
- in_valid dropping mid-packet: the lock is retained and out_valid follows in_valid.
- Reset values:
  - All outputs IDLE; all input locks cleared; rr_ptr=0
  - out_valid=0, in_ready=0, out_busy=0, out_sel=0
- Reset asserted mid-packet aborts every lock on the next edge. No flit completes that cycle.

Optional Feature:
- Macro: ROUTER_SWITCH_ALLOC_STATS_EN.
- Defined:
  - Adds output port out_flit_cnt (5*STAT_W) and input clear_stats (1).
  - Each counter increments on every transfer on its output and saturates at all-ones.
  - Counters are cleared by reset or clear_stats. If clear_stats and a transfer coincide, clear wins.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package router_pkg holds:
  - port-index enum (PORT_LOCAL..PORT_SOUTH)
  - NUM_OUT=5
  - localparam PORT_W=3
  - FSM state enum {ST_IDLE, ST_LOCKED}
- One sub-module, router_route_calc: combinational XY route from (dest_x, dest_y) to a 3-bit port. Instantiated N_IN times.

Test Plan:
- Single-flit packet on input 2, dx=+5, dy=-3, out_ready=1 -> out_busy[1] rises 1 cycle later, out_sel[1]=2, one transfer, output 1 IDLE the following cycle.
- Inputs 0 and 3 both heading dx=0, dy=+1, out_ready=1, each packet 3 flits -> NORTH serves input 0 first (3 transfers), then input 3; rr_ptr[3]=1 after the first packet and 4 after the second.
- Concurrent routes: input 0 dx=-1, input 1 dx=0 dy=0 -> WEST and LOCAL both locked in the same cycle with no cross-blocking.
- Backpressure: locked 4-flit packet with out_ready toggling 1,0,1,0,... -> exactly 4 transfers, in_ready mirrors out_ready, lock released only after the tail.
- Reset asserted mid-packet (after 2 of 4 flits) -> the following cycle all out_busy=0, out_valid=0, in_ready=0; a new head is granted normally after reset deasserts.
- STATS_EN: 70000 transfers on EAST with STAT_W=16 -> counter saturates at 65535; clear_stats pulse coinciding with a transfer -> counter reads 0.
